trap_irq_ctrl: RTL and testbench
================================

Name: trap_irq_ctrl

Overview:
- Parametrised machine-mode trap and interrupt controller for the 5-stage RV32 core.
- Generalises the core's fixed two-source scheme (external and timer) to NUM_IRQ level-sensitive sources with fixed priority.
- Adds an input synchroniser, vectored mtvec mode, WFI sleep/wake sequencing and MRET return, all under the bus `waiting` freeze.
- Sits beside the ID stage and drives the PC-redirect and front-end stall.

Parameters:
NUM_IRQ, 2, number of interrupt sources (1..16); irq[0]=external (cause 11), irq[1]=timer (cause 7), irq[i>=2] = cause 16+i-2.
SYNC_STAGES, 2, flop stages on each irq input (1..3).
VECTORED_EN, 1, 1 enables mtvec.MODE=1 vectored entry; 0 forces direct mode.
RESET_MTVEC, 32'h0000_0000, reset value of mtvec.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
irq  in  NUM_IRQ  level interrupt requests, asynchronous to clk
waiting  in  1  bus stall; 1 freezes all state
wfi_exec  in  1  WFI instruction in ID (valid when waiting=0)
mret_exec  in  1  MRET instruction in ID
pc_curr  in  32  PC of the instruction in ID; saved to mepc on trap
csr_we  in  1  CSR write strobe from EXE
csr_addr  in  12  CSR address
csr_wdata  in  32  CSR write data
csr_rdata  out  32  combinational read of csr_addr
redirect  out  1  one-cycle pulse: flush IF/ID, load redirect_pc
redirect_pc  out  32  target PC (trap vector or mepc)
stall  out  1  hold PC and IF/ID (WFI sleep)
sleeping  out  1  FSM in SLEEP

Behaviour:
- Reset (async, rst=1): FSM=RUN; redirect=0, redirect_pc=0, stall=0, sleeping=0; mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mtvec=RESET_MTVEC; synchronisers cleared.
- waiting=1: no register, FSM or synchroniser-output change; redirect forced 0; stall holds its value.
- CSRs: mstatus 0x300 (MIE bit3, MPIE bit7; other bits read 0); mie 0x304 and mip 0x344 (bit = cause code of each source; mip read-only, equals synchronised irq); mtvec 0x305 (bits[1:0]=MODE, read-only 0 when VECTORED_EN=0, MODE=2/3 behave as 0); mepc 0x341 (bits[1:0] forced 0); mcause 0x342 (bit31=1 for interrupts). Unknown addresses read 0, and writes to them are ignored.
- pending = sync_irq & mie_mask. sel = lowest index set in pending (index 0 highest priority).
- FSM RUN:
  - Priority when waiting=0: trap > mret > wfi.
  - Trap when MIE=1 and |pending: redirect=1 next cycle; redirect_pc = base if MODE=0, else base + 4*cause; mepc<=pc_curr; mcause<={1,cause}; MPIE<=MIE; MIE<=0.
  - mret_exec (no trap): redirect=1, redirect_pc=mepc; MIE<=MPIE; MPIE<=1.
  - wfi_exec with pending=0: go to SLEEP, stall=1, sleeping=1. With pending!=0, WFI is a nop (and traps if MIE=1).
- FSM SLEEP:
  - Wake when |pending, regardless of MIE. Next cycle: stall=0, sleeping=0, FSM=RUN.
  - If MIE=1, the trap fires in the same wake cycle, with mepc=pc_curr (the instruction after the WFI).
  - If MIE=0, execution resumes with no redirect.
- Latency: irq rising edge to trap redirect = SYNC_STAGES+1 cycles, with waiting=0 throughout.
- Same-cycle CSR write and trap/mret: the hardware update of mstatus/mepc/mcause wins and the software write to those CSRs is dropped. Writes to mie/mtvec always apply.
- A CSR write that sets MIE while pending is set traps on the following cycle, not the write cycle.
- irq deasserted before the trap is taken: nothing is latched and no trap occurs (level-sensitive).
- rst asserted mid-SLEEP or mid-redirect: immediately returns to reset state, with no residual redirect pulse.

Test Plan:
- Reset: rst=1 → all outputs 0, mtvec reads RESET_MTVEC, mstatus reads 0.
- Direct trap: mtvec=0x100, mie bit11=1, MIE=1, irq[0] rises, pc_curr=0x2C → redirect pulse after 3 cycles (SYNC_STAGES=2), redirect_pc=0x100, mepc=0x2C, mcause=0x8000000B, MIE=0, MPIE=1.
- Vectored + priority: mtvec=0x201, irq[0] and irq[1] rise together, both enabled → redirect_pc=0x22C (cause 11). A subsequent MRET gives redirect_pc=mepc, MIE=1; the timer trap then follows to 0x21C.
- WFI wake: MIE=0, mie bit7=1, wfi_exec → stall=1, sleeping=1. irq[1] rises → stall drops SYNC_STAGES+1 cycles later with no redirect. Repeat with MIE=1 → trap to vector.
- waiting freeze: irq[0] pending with MIE=1, waiting=1 for 5 cycles → no redirect and no state change; redirect fires the first cycle after waiting falls.
- Collision: csr_we to mepc=0x400 in the trap cycle → mepc=pc_curr. csr_we to mie in the same cycle → mie updated.

Source files
------------

// File: rtl/trap_irq_ctrl.sv
// Machine-mode trap/interrupt controller: NUM_IRQ level sources with fixed priority,
// input synchronisers, direct/vectored mtvec, WFI sleep/wake and MRET, frozen by `waiting`.
module trap_irq_ctrl #(
   parameter int          NUM_IRQ     = 2,
   parameter int          SYNC_STAGES = 2,
   parameter int          VECTORED_EN = 1,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               waiting,
   input  logic               wfi_exec,
   input  logic               mret_exec,
   input  logic [31:0]        pc_curr,
   input  logic               csr_we,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   output logic               redirect,
   output logic [31:0]        redirect_pc,
   output logic               stall,
   output logic               sleeping
);

   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MIP     = 12'h344;

   localparam logic [31:0] MTVEC_RST = (VECTORED_EN != 0) ? RESET_MTVEC
                                                          : {RESET_MTVEC[31:2], 2'b00};

   function automatic logic [4:0] cause_of(input int idx);
      if (idx == 0)      return 5'd11;
      else if (idx == 1) return 5'd7;
      else               return 5'(14 + idx);
   endfunction

   typedef enum logic {ST_RUN, ST_SLEEP} state_t;

   state_t                          r_state;
   state_t                          w_state_next;
   logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] r_sync;
   logic                            r_mie_bit;
   logic                            r_mpie_bit;
   logic [NUM_IRQ-1:0]              r_mie_en;
   logic [31:0]                     r_mtvec;
   logic [31:0]                     r_mepc;
   logic [31:0]                     r_mcause;
   logic                            r_redirect;
   logic [31:0]                     r_redirect_pc;

   logic [NUM_IRQ-1:0]              w_sync_irq;
   logic [NUM_IRQ-1:0]              w_pending;
   logic                            w_any_pending;
   logic [4:0]                      w_sel_cause;
   logic [NUM_IRQ-1:0]              w_mie_wr;
   logic [31:0]                     w_mie32;
   logic [31:0]                     w_mip32;
   logic [31:0]                     w_base;
   logic                            w_vectored;
   logic [31:0]                     w_trap_pc;
   logic                            w_take_trap;
   logic                            w_take_mret;

   assign w_sync_irq    = r_sync[SYNC_STAGES-1];
   assign w_pending     = w_sync_irq & r_mie_en;
   assign w_any_pending = |w_pending;

   // Each source owns the mie/mip bit at its cause code.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_mie_wr
         localparam logic [4:0] L_CAUSE = cause_of(gi);
         assign w_mie_wr[gi] = csr_wdata[L_CAUSE];
      end
   endgenerate

   always_comb begin
      w_mie32 = '0;
      w_mip32 = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         w_mie32[cause_of(i)] = r_mie_en[i];
         w_mip32[cause_of(i)] = w_sync_irq[i];
      end
   end

   // Scan from the top so the lowest pending index wins.
   always_comb begin
      w_sel_cause = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_pending[i]) w_sel_cause = cause_of(i);
      end
   end

   assign w_base     = {r_mtvec[31:2], 2'b00};
   assign w_vectored = (VECTORED_EN != 0) && (r_mtvec[1:0] == 2'b01);
   assign w_trap_pc  = w_vectored ? (w_base + {25'b0, w_sel_cause, 2'b00}) : w_base;

   always_comb begin
      w_state_next = r_state;
      w_take_trap  = 1'b0;
      w_take_mret  = 1'b0;
      if (!waiting) begin
         case (r_state)
            ST_RUN: begin
               if (r_mie_bit && w_any_pending) begin
                  w_take_trap = 1'b1;
               end else if (mret_exec) begin
                  w_take_mret = 1'b1;
               end else if (wfi_exec && !w_any_pending) begin
                  w_state_next = ST_SLEEP;
               end
            end
            ST_SLEEP: begin
               if (w_any_pending) begin
                  w_state_next = ST_RUN;
                  w_take_trap  = r_mie_bit;
               end
            end
            default: w_state_next = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_sync        <= '0;
         r_mie_bit     <= 1'b0;
         r_mpie_bit    <= 1'b0;
         r_mie_en      <= '0;
         r_mtvec       <= MTVEC_RST;
         r_mepc        <= '0;
         r_mcause      <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
      end else if (!waiting) begin
         r_state    <= w_state_next;
         r_redirect <= w_take_trap | w_take_mret;
         r_sync[0]  <= irq;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];

         // Hardware trap/return updates take precedence over software writes.
         if (w_take_trap) begin
            r_redirect_pc <= w_trap_pc;
            r_mepc        <= {pc_curr[31:2], 2'b00};
            r_mcause      <= {1'b1, 26'b0, w_sel_cause};
            r_mpie_bit    <= r_mie_bit;
            r_mie_bit     <= 1'b0;
         end else if (w_take_mret) begin
            r_redirect_pc <= r_mepc;
            r_mie_bit     <= r_mpie_bit;
            r_mpie_bit    <= 1'b1;
         end else if (csr_we) begin
            case (csr_addr)
               A_MSTATUS: begin
                  r_mie_bit  <= csr_wdata[3];
                  r_mpie_bit <= csr_wdata[7];
               end
               A_MEPC:   r_mepc   <= {csr_wdata[31:2], 2'b00};
               A_MCAUSE: r_mcause <= csr_wdata;
               default: ;
            endcase
         end

         if (csr_we && csr_addr == A_MIE) r_mie_en <= w_mie_wr;
         if (csr_we && csr_addr == A_MTVEC)
            r_mtvec <= (VECTORED_EN != 0) ? csr_wdata : {csr_wdata[31:2], 2'b00};
      end
   end

   always_comb begin
      case (csr_addr)
         A_MSTATUS: csr_rdata = {24'b0, r_mpie_bit, 3'b0, r_mie_bit, 3'b0};
         A_MIE:     csr_rdata = w_mie32;
         A_MTVEC:   csr_rdata = r_mtvec;
         A_MEPC:    csr_rdata = r_mepc;
         A_MCAUSE:  csr_rdata = r_mcause;
         A_MIP:     csr_rdata = w_mip32;
         default:   csr_rdata = '0;
      endcase
   end

   assign redirect    = r_redirect & ~waiting;
   assign redirect_pc = r_redirect_pc;
   assign stall       = (r_state == ST_SLEEP);
   assign sleeping    = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// Directed bench for trap_irq_ctrl (NUM_IRQ=2, SYNC_STAGES=2, vectored enabled).
module tb_trap_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  irq;
   logic        waiting;
   logic        wfi_exec;
   logic        mret_exec;
   logic [31:0] pc_curr;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        sleeping;

   int n_checks = 0;
   int n_errors = 0;

   trap_irq_ctrl #(
      .NUM_IRQ(2), .SYNC_STAGES(2), .VECTORED_EN(1), .RESET_MTVEC(32'h0000_1000)
   ) dut (
      .clk(clk), .rst(rst), .irq(irq), .waiting(waiting), .wfi_exec(wfi_exec),
      .mret_exec(mret_exec), .pc_curr(pc_curr), .csr_we(csr_we), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .redirect(redirect),
      .redirect_pc(redirect_pc), .stall(stall), .sleeping(sleeping)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-14s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic csr_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csr_addr = addr;
      #1;
      chk(tag, csr_rdata, exp);
   endtask

   task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
      csr_we    = 1'b1;
      csr_addr  = addr;
      csr_wdata = data;
      step();
      csr_we    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; irq = '0; waiting = 1'b0; wfi_exec = 1'b0; mret_exec = 1'b0;
      pc_curr = '0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;

      // Reset state
      step(); step();
      chk("rst_redirect", {31'b0, redirect}, 32'h0);
      chk("rst_rpc", redirect_pc, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      chk("rst_sleeping", {31'b0, sleeping}, 32'h0);
      csr_rd("rst_mtvec", 12'h305, 32'h0000_1000);
      csr_rd("rst_mstatus", 12'h300, 32'h0);
      rst = 1'b0;
      step();

      // Direct trap from external source
      csr_wr(12'h305, 32'h0000_0100);
      csr_wr(12'h304, 32'h0000_0800);
      csr_wr(12'h300, 32'h0000_0008);
      csr_rd("mstatus_mie", 12'h300, 32'h0000_0008);
      pc_curr = 32'h2C;
      irq = 2'b01;
      step(); step();
      chk("dir_early", {31'b0, redirect}, 32'h0);
      csr_rd("dir_mip", 12'h344, 32'h0000_0800);
      step();
      chk("dir_redirect", {31'b0, redirect}, 32'h1);
      chk("dir_rpc", redirect_pc, 32'h100);
      csr_rd("dir_mepc", 12'h341, 32'h2C);
      csr_rd("dir_mcause", 12'h342, 32'h8000_000B);
      csr_rd("dir_mstatus", 12'h300, 32'h0000_0080);
      step();
      chk("dir_pulse_end", {31'b0, redirect}, 32'h0);
      irq = 2'b00;
      step(); step(); step();

      // Vectored entry, priority, MRET, then timer trap
      csr_wr(12'h305, 32'h0000_0201);
      csr_wr(12'h304, 32'h0000_0880);
      csr_wr(12'h300, 32'h0000_0008);
      pc_curr = 32'h48;
      irq = 2'b11;
      step(); step();
      chk("vec_early", {31'b0, redirect}, 32'h0);
      step();
      chk("vec_redirect", {31'b0, redirect}, 32'h1);
      chk("vec_rpc", redirect_pc, 32'h22C);
      csr_rd("vec_mcause", 12'h342, 32'h8000_000B);
      irq = 2'b10;
      step(); step(); step();
      chk("vec_no_retrap", {31'b0, redirect}, 32'h0);
      mret_exec = 1'b1;
      pc_curr = 32'h60;
      step();
      mret_exec = 1'b0;
      chk("mret_redirect", {31'b0, redirect}, 32'h1);
      chk("mret_rpc", redirect_pc, 32'h48);
      csr_rd("mret_mstatus", 12'h300, 32'h0000_0088);
      step();
      chk("tmr_redirect", {31'b0, redirect}, 32'h1);
      chk("tmr_rpc", redirect_pc, 32'h21C);
      csr_rd("tmr_mcause", 12'h342, 32'h8000_0007);
      csr_rd("tmr_mepc", 12'h341, 32'h60);
      irq = 2'b00;
      step(); step(); step();

      // WFI sleep with MIE=0: wake without redirect
      csr_wr(12'h304, 32'h0000_0080);
      wfi_exec = 1'b1;
      step();
      wfi_exec = 1'b0;
      chk("wfi_stall", {31'b0, stall}, 32'h1);
      chk("wfi_sleeping", {31'b0, sleeping}, 32'h1);
      step();
      irq = 2'b10;
      step(); step();
      chk("wfi_still", {31'b0, stall}, 32'h1);
      step();
      chk("wake_stall", {31'b0, stall}, 32'h0);
      chk("wake_sleeping", {31'b0, sleeping}, 32'h0);
      chk("wake_noredir", {31'b0, redirect}, 32'h0);
      irq = 2'b00;
      step(); step(); step();

      // WFI sleep with MIE=1: wake traps to vector
      csr_wr(12'h300, 32'h0000_0008);
      wfi_exec = 1'b1;
      step();
      wfi_exec = 1'b0;
      chk("wfi2_stall", {31'b0, stall}, 32'h1);
      pc_curr = 32'h84;
      irq = 2'b10;
      step(); step();
      chk("wfi2_noredir", {31'b0, redirect}, 32'h0);
      step();
      chk("wake2_stall", {31'b0, stall}, 32'h0);
      chk("wake2_redirect", {31'b0, redirect}, 32'h1);
      chk("wake2_rpc", redirect_pc, 32'h21C);
      csr_rd("wake2_mepc", 12'h341, 32'h84);
      irq = 2'b00;
      step(); step(); step();

      // MIE set by CSR write while pending, then waiting freeze
      csr_wr(12'h304, 32'h0000_0880);
      irq = 2'b01;
      step(); step();
      csr_wr(12'h300, 32'h0000_0008);
      chk("wr_cycle_nored", {31'b0, redirect}, 32'h0);
      waiting = 1'b1;
      pc_curr = 32'h90;
      for (int k = 0; k < 5; k++) step();
      chk("wait_noredir", {31'b0, redirect}, 32'h0);
      csr_rd("wait_mstatus", 12'h300, 32'h0000_0008);
      csr_rd("wait_mepc", 12'h341, 32'h84);
      waiting = 1'b0;
      #1;
      chk("wait_fall", {31'b0, redirect}, 32'h0);
      step();
      chk("wait_redirect", {31'b0, redirect}, 32'h1);
      chk("wait_rpc", redirect_pc, 32'h22C);
      csr_rd("wait_mepc2", 12'h341, 32'h90);
      step();

      // Collision: trap beats mepc write, mie write still applies
      csr_wr(12'h300, 32'h0000_0008);
      pc_curr = 32'hA0;
      csr_wr(12'h341, 32'h0000_0400);
      chk("col_redirect", {31'b0, redirect}, 32'h1);
      csr_rd("col_mepc", 12'h341, 32'hA0);
      step();
      csr_wr(12'h300, 32'h0000_0008);
      csr_wr(12'h304, 32'h0000_0080);
      chk("col2_redirect", {31'b0, redirect}, 32'h1);
      csr_rd("col2_mie", 12'h304, 32'h0000_0080);
      irq = 2'b00;
      step(); step(); step();

      // Asynchronous reset during SLEEP
      wfi_exec = 1'b1;
      step();
      wfi_exec = 1'b0;
      chk("pre_rst_sleep", {31'b0, sleeping}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_stall", {31'b0, stall}, 32'h0);
      chk("arst_sleeping", {31'b0, sleeping}, 32'h0);
      chk("arst_redirect", {31'b0, redirect}, 32'h0);
      csr_rd("arst_mie", 12'h304, 32'h0);
      csr_rd("arst_mtvec", 12'h305, 32'h0000_1000);
      step();
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
